register_bank: RTL and testbench
================================

# register_bank

Parametrised multi-register bank that extends the single clear/load/decrement/increment register. It adds:
- configurable width and register count;
- shift, rotate and half-load functions;
- carry and zero status flags;
- two independent read ports.

It serves as the general-purpose/address register block in the datapath. One register is modified per clock; the ALU and address logic read any two registers combinationally.

## Interface
Parameters:
- NBits, 16, data width of every register and of i/qa/qb; even, ≥ 4
- NRegs, 4, number of registers; power of two, ≥ 2
- ABits, 2, select width; must equal log2(NRegs)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset; overrides e
- e  input  1  operation enable; no state change when 0
- wsel  input  ABits  target register of the operation
- funsel  input  3  function code (see Operation)
- i  input  NBits  load data
- rsel_a  input  ABits  read port A select
- rsel_b  input  ABits  read port B select
- qa  output  NBits  contents of register rsel_a
- qb  output  NBits  contents of register rsel_b
- cflag  output  1  carry/borrow/shifted-out bit of last flag-updating op
- zflag  output  1  1 when last executed op left the target register 0

## Operation
- Reset (rst=1 at an edge):
  - all registers, cflag and zflag go to 0;
  - qa/qb read 0 on the next cycle.
- e=1, rst=0: apply funsel to register R = reg[wsel]. Other registers are unchanged.
  - 000 clear: R←0; cflag←0
  - 001 load: R←i; cflag unchanged
  - 010 decrement: R←R−1 (wraps 0→all-ones); cflag←1 iff R was 0 (borrow)
  - 011 increment: R←R+1 (wraps all-ones→0); cflag←1 iff R was all-ones
  - 100 shift left logical: R←{R[NBits-2:0],0}; cflag←old R[NBits-1]
  - 101 shift right logical: R←{0,R[NBits-1:1]}; cflag←old R[0]
  - 110 rotate left through carry: R←{R[NBits-2:0],cflag}; cflag←old R[NBits-1]
  - 111 load low half: R[NBits/2-1:0]←i[NBits/2-1:0]; high half kept; cflag unchanged
- zflag:
  - updated on every executed op (e=1) to (new R == 0);
  - held when e=0.
- Arithmetic is unsigned, modulo 2^NBits, unless the saturation macro is compiled in.
- Reads:
  - qa/qb are purely combinational muxes of the register array;
  - rsel_a = rsel_b is legal, and both ports then show the same value;
  - there is no write-to-read bypass.

## Timing
- Write latency is 1 cycle: the new value is visible on qa/qb and in the flags after the rising edge that samples e=1.
- In the cycle of the operation, reading the target register shows the old value.
- Read latency is 0 (combinational from registered state).
- rsel/wsel/funsel/i are sampled only at the rising edge; glitches between edges have no effect on state.
- rst asserted mid-sequence:
  - that edge clears everything;
  - the op requested in the same cycle is discarded.
- Back-to-back ops on the same register chain correctly: each op uses the value produced by the previous edge.
- cflag used by 110 is the value before the current edge.

## Configuration
- Macro: REGISTER_BANK_SAT_EN.
- Defined:
  - increment at all-ones holds all-ones;
  - decrement at 0 holds 0;
  - cflag is still set to 1 in those cases;
  - zflag is computed from the saturated result.
- Undefined: increment/decrement wrap as described in Operation. All other functions are unaffected in both builds.

## Test plan
All scenarios use NBits=16, NRegs=4.
- Reset then read: rst=1 for one edge → qa=qb=0x0000 for all rsel, cflag=0, zflag=0.
- Load and dual read:
  - stimulus: load reg1=0x1234, then reg2=0xABCD; rsel_a=1, rsel_b=2;
  - response: qa=0x1234, qb=0xABCD; reg0 and reg3 still 0.
- Wrap/flags:
  - reg0=0xFFFF, increment → 0x0000, cflag=1, zflag=1;
  - then decrement → 0xFFFF, cflag=1, zflag=0;
  - with REGISTER_BANK_SAT_EN, the increment gives 0xFFFF, cflag=1, zflag=0.
- Shifts/rotate:
  - reg3=0x8001, shift left → 0x0002, cflag=1;
  - rotate left → 0x0005, cflag=0;
  - shift right → 0x0002, cflag=1.
- Half load and enable:
  - reg1=0x1234, funsel=111 with i=0xFFAB → 0x12AB;
  - e=0 with funsel=000 → reg1 stays 0x12AB, flags held.
- Reset priority: rst=1 and e=1 with load 0x5555 on the same edge → register reads 0x0000 afterwards.

Source files
------------

// File: rtl/register_bank.sv
//==============================================================================
// Module      : register_bank
// Description : Parametrised bank of NRegs registers, NBits wide. One register
//               per clock is cleared, loaded, decremented, incremented,
//               shifted, rotated through carry or half-loaded. Carry and zero
//               status flags are kept. Two independent combinational read
//               ports are provided.
//
// Ports       : clk     - clock, all state changes on rising edge
//               rst     - synchronous active-high reset (overrides e)
//               e       - operation enable
//               wsel    - target register of the operation
//               funsel  - function code
//               i       - load data
//               rsel_a  - read port A select
//               rsel_b  - read port B select
//               qa, qb  - contents of the selected registers
//               cflag   - carry/borrow/shifted-out bit of last flag-updating op
//               zflag   - 1 when the last executed op left the target at 0
//
// Options     : REGISTER_BANK_SAT_EN - when defined, increment and decrement
//               saturate at all-ones / zero instead of wrapping.
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module register_bank #(
    parameter int NBits = 16,
    parameter int NRegs = 4,
    parameter int ABits = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic [ABits-1:0] wsel,
    input  logic [2:0]       funsel,
    input  logic [NBits-1:0] i,
    input  logic [ABits-1:0] rsel_a,
    input  logic [ABits-1:0] rsel_b,
    output logic [NBits-1:0] qa,
    output logic [NBits-1:0] qb,
    output logic             cflag,
    output logic             zflag
);

    localparam logic [2:0] c_FN_CLR  = 3'b000;
    localparam logic [2:0] c_FN_LD   = 3'b001;
    localparam logic [2:0] c_FN_DEC  = 3'b010;
    localparam logic [2:0] c_FN_INC  = 3'b011;
    localparam logic [2:0] c_FN_SHL  = 3'b100;
    localparam logic [2:0] c_FN_SHR  = 3'b101;
    localparam logic [2:0] c_FN_ROL  = 3'b110;
    localparam logic [2:0] c_FN_LDLO = 3'b111;

    localparam int             c_HALF = NBits / 2;
    localparam logic [NBits-1:0] c_ZERO = '0;
    localparam logic [NBits-1:0] c_ONES = '1;
    localparam logic [NBits-1:0] c_ONE  = NBits'(1);

    logic [NBits-1:0] r_regs [NRegs];
    logic             r_cflag;
    logic             r_zflag;

    logic [NBits-1:0] w_old;
    logic [NBits-1:0] w_new;
    logic             w_cnew;
    logic             w_is_zero;
    logic             w_is_ones;

    // Current value of the target register; the op is computed from it.
    assign w_old     = r_regs[wsel];
    assign w_is_zero = (w_old == c_ZERO);
    assign w_is_ones = (w_old == c_ONES);

    always_comb begin
        w_new  = w_old;
        w_cnew = r_cflag;
        case (funsel)
            c_FN_CLR: begin
                w_new  = c_ZERO;
                w_cnew = 1'b0;
            end
            c_FN_LD: begin
                w_new  = i;
            end
            c_FN_DEC: begin
`ifdef REGISTER_BANK_SAT_EN
                w_new  = w_is_zero ? c_ZERO : (w_old - c_ONE);
`else
                w_new  = w_old - c_ONE;
`endif
                w_cnew = w_is_zero;
            end
            c_FN_INC: begin
`ifdef REGISTER_BANK_SAT_EN
                w_new  = w_is_ones ? c_ONES : (w_old + c_ONE);
`else
                w_new  = w_old + c_ONE;
`endif
                w_cnew = w_is_ones;
            end
            c_FN_SHL: begin
                w_new  = {w_old[NBits-2:0], 1'b0};
                w_cnew = w_old[NBits-1];
            end
            c_FN_SHR: begin
                w_new  = {1'b0, w_old[NBits-1:1]};
                w_cnew = w_old[0];
            end
            c_FN_ROL: begin
                // Carry-in is the flag as registered before this edge.
                w_new  = {w_old[NBits-2:0], r_cflag};
                w_cnew = w_old[NBits-1];
            end
            c_FN_LDLO: begin
                w_new  = {w_old[NBits-1:c_HALF], i[c_HALF-1:0]};
            end
            default: begin
                w_new  = w_old;
                w_cnew = r_cflag;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NRegs; k++) begin
                r_regs[k] <= c_ZERO;
            end
            r_cflag <= 1'b0;
            r_zflag <= 1'b0;
        end else if (e) begin
            r_regs[wsel] <= w_new;
            r_cflag      <= w_cnew;
            r_zflag      <= (w_new == c_ZERO);
        end
    end

    // Reads come straight from registered state; no write-to-read bypass.
    assign qa    = r_regs[rsel_a];
    assign qb    = r_regs[rsel_b];
    assign cflag = r_cflag;
    assign zflag = r_zflag;

endmodule

`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none

module tb_register_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        e = 1'b0;
    logic [1:0]  wsel = '0;
    logic [2:0]  funsel = '0;
    logic [15:0] i = '0;
    logic [1:0]  rsel_a = '0;
    logic [1:0]  rsel_b = '0;
    logic [15:0] qa;
    logic [15:0] qb;
    logic        cflag;
    logic        zflag;

    int n_cmp = 0;
    int n_err = 0;

    register_bank #(.NBits(16), .NRegs(4), .ABits(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .e      (e),
        .wsel   (wsel),
        .funsel (funsel),
        .i      (i),
        .rsel_a (rsel_a),
        .rsel_b (rsel_b),
        .qa     (qa),
        .qb     (qb),
        .cflag  (cflag),
        .zflag  (zflag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        e;
        logic [1:0]  wsel;
        logic [2:0]  fs;
        logic [15:0] i;
        logic [1:0]  ra;
        logic [1:0]  rb;
        logic [15:0] eqa;
        logic [15:0] eqb;
        logic        ec;
        logic        ez;
    } vec_t;

    function automatic vec_t mk(logic r, logic en, logic [1:0] ws, logic [2:0] fs,
                                logic [15:0] d, logic [1:0] ra, logic [1:0] rb,
                                logic [15:0] eqa, logic [15:0] eqb, logic ec, logic ez);
        vec_t v;
        v.rst = r; v.e = en; v.wsel = ws; v.fs = fs; v.i = d; v.ra = ra; v.rb = rb;
        v.eqa = eqa; v.eqb = eqb; v.ec = ec; v.ez = ez;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic [1:0] ws,
                         input logic [2:0] fs, input logic [15:0] d,
                         input logic [1:0] ra, input logic [1:0] rb);
        rst = r; e = en; wsel = ws; funsel = fs; i = d; rsel_a = ra; rsel_b = rb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[21];

    initial begin
        // rst e  wsel fs     i        ra rb  qa       qb       c  z
        vecs[0]  = mk(1, 0, 0, 3'b000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 0);
        vecs[1]  = mk(0, 0, 0, 3'b000, 16'h0000, 2, 3, 16'h0000, 16'h0000, 0, 0);
        vecs[2]  = mk(0, 1, 1, 3'b001, 16'h1234, 1, 2, 16'h1234, 16'h0000, 0, 0);
        vecs[3]  = mk(0, 1, 2, 3'b001, 16'hABCD, 1, 2, 16'h1234, 16'hABCD, 0, 0);
        vecs[4]  = mk(0, 0, 0, 3'b000, 16'h0000, 0, 3, 16'h0000, 16'h0000, 0, 0);
        vecs[5]  = mk(0, 1, 0, 3'b001, 16'hFFFF, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0);
`ifdef REGISTER_BANK_SAT_EN
        vecs[6]  = mk(0, 1, 0, 3'b011, 16'h0000, 0, 1, 16'hFFFF, 16'h1234, 1, 0);
        vecs[7]  = mk(0, 1, 0, 3'b010, 16'h0000, 0, 1, 16'hFFFE, 16'h1234, 0, 0);
`else
        vecs[6]  = mk(0, 1, 0, 3'b011, 16'h0000, 0, 1, 16'h0000, 16'h1234, 1, 1);
        vecs[7]  = mk(0, 1, 0, 3'b010, 16'h0000, 0, 1, 16'hFFFF, 16'h1234, 1, 0);
`endif
        vecs[8]  = mk(0, 1, 0, 3'b000, 16'h0000, 0, 3, 16'h0000, 16'h0000, 0, 1);
        vecs[9]  = mk(0, 1, 3, 3'b001, 16'h8001, 3, 0, 16'h8001, 16'h0000, 0, 0);
        vecs[10] = mk(0, 1, 3, 3'b100, 16'h0000, 3, 3, 16'h0002, 16'h0002, 1, 0);
        vecs[11] = mk(0, 1, 3, 3'b110, 16'h0000, 3, 1, 16'h0005, 16'h1234, 0, 0);
        vecs[12] = mk(0, 1, 3, 3'b101, 16'h0000, 3, 1, 16'h0002, 16'h1234, 1, 0);
        vecs[13] = mk(0, 1, 1, 3'b111, 16'hFFAB, 1, 3, 16'h12AB, 16'h0002, 1, 0);
        vecs[14] = mk(0, 0, 1, 3'b000, 16'h0000, 1, 3, 16'h12AB, 16'h0002, 1, 0);
        vecs[15] = mk(0, 1, 3, 3'b010, 16'h0000, 3, 2, 16'h0001, 16'hABCD, 0, 0);
        vecs[16] = mk(0, 1, 2, 3'b001, 16'h8000, 2, 3, 16'h8000, 16'h0001, 0, 0);
        vecs[17] = mk(0, 1, 2, 3'b100, 16'h0000, 2, 1, 16'h0000, 16'h12AB, 1, 1);
        vecs[18] = mk(0, 1, 2, 3'b011, 16'h0000, 2, 2, 16'h0001, 16'h0001, 0, 0);
        vecs[19] = mk(0, 1, 1, 3'b001, 16'h00F0, 1, 2, 16'h00F0, 16'h0001, 0, 0);
        // reset wins over a simultaneous load
        vecs[20] = mk(1, 1, 1, 3'b001, 16'h5555, 1, 2, 16'h0000, 16'h0000, 0, 0);

        @(negedge clk);
        for (int k = 0; k < 21; k++) begin
            drive(vecs[k].rst, vecs[k].e, vecs[k].wsel, vecs[k].fs, vecs[k].i,
                  vecs[k].ra, vecs[k].rb);
            step();
            chk($sformatf("v%0d qa", k), qa, vecs[k].eqa);
            chk($sformatf("v%0d qb", k), qb, vecs[k].eqb);
            chk($sformatf("v%0d cflag", k), {15'd0, cflag}, {15'd0, vecs[k].ec});
            chk($sformatf("v%0d zflag", k), {15'd0, zflag}, {15'd0, vecs[k].ez});
        end

        // All four registers read zero after the reset above.
        for (int r = 0; r < 4; r++) begin
            drive(0, 0, 0, 3'b000, 16'h0000, r[1:0], r[1:0]);
            #1;
            chk($sformatf("post-rst reg%0d", r), qa, 16'h0000);
        end

        // Target register shows the old value before the edge, new after.
        drive(0, 1, 0, 3'b001, 16'h7777, 0, 0);
        #1;
        chk("pre-edge old value", qa, 16'h0000);
        step();
        chk("post-edge new value", qa, 16'h7777);

        // Back-to-back increments chain on the same register.
        drive(0, 1, 0, 3'b011, 16'h0000, 0, 0);
        step();
        chk("b2b inc 1", qa, 16'h7778);
        step();
        chk("b2b inc 2", qa, 16'h7779);
        step();
        chk("b2b inc 3", qb, 16'h777A);

        // Inputs toggled between edges with e=0 leave state alone.
        drive(0, 0, 0, 3'b000, 16'h0000, 0, 0);
        #2 i = 16'hDEAD; funsel = 3'b001;
        #2 e = 1'b0;
        step();
        chk("no glitch write", qa, 16'h777A);

        // Decrement from zero: wrap or saturate.
        drive(0, 1, 2, 3'b000, 16'h0000, 2, 2);
        step();
        drive(0, 1, 2, 3'b010, 16'h0000, 2, 2);
        step();
`ifdef REGISTER_BANK_SAT_EN
        chk("dec at 0 value", qa, 16'h0000);
        chk("dec at 0 zflag", {15'd0, zflag}, 16'h0001);
`else
        chk("dec at 0 value", qa, 16'hFFFF);
        chk("dec at 0 zflag", {15'd0, zflag}, 16'h0000);
`endif
        chk("dec at 0 cflag", {15'd0, cflag}, 16'h0001);

        drive(0, 0, 0, 3'b000, 16'h0000, 0, 0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
